voltage_uart_reporter: RTL and testbench

- Downstream consumer of the voltage monitor's AXI4-Stream millivolt output.
- Accepts one 32-bit word, converts the low 16 bits to five ASCII decimal digits with a sequential double-dabble converter, and transmits the digits plus CR LF as 8N1 UART frames on a single pin.
- Drives the board's USB-UART bridge so a host terminal shows one reading per line at the sample rate.

---
 rtl/voltage_uart_reporter.sv | 164 ++++++++++++++++
 tb/tb_voltage_uart_reporter.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/voltage_uart_reporter.sv
// Converts an AXI4-Stream millivolt reading to "DDDDD\r\n" and sends it as 8N1 UART frames.
// Optional macro LEADING_ZERO_BLANK_EN: leading zero digits (never the units) are sent as spaces.
module voltage_uart_reporter #(
    parameter int unsigned CLK_HZ = 100_000_000,
    parameter int unsigned BAUD   = 115_200
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] s_axis_tdata,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    output logic        uart_tx,
    output logic        busy
);
    localparam int unsigned BAUD_DIV = CLK_HZ / BAUD;
    localparam int unsigned BaudW    = $clog2(BAUD_DIV);

    typedef enum logic [1:0] {StIdle, StConvert, StLoad, StSend} state_e;

    state_e             state_q, state_d;
    logic [15:0]        data_q, data_d;
    logic [35:0]        dd_q, dd_d;
    logic [35:0]        dd_adj;
    logic [4:0]         conv_cnt_q, conv_cnt_d;
    logic [2:0]         char_idx_q, char_idx_d;
    logic [BaudW-1:0]   baud_cnt_q, baud_cnt_d;
    logic [3:0]         bit_cnt_q, bit_cnt_d;
    logic [8:0]         shift_q, shift_d;
    logic               tx_q, tx_d;
    logic               tready_q;
    logic               busy_q;
    logic [19:0]        bcd;
    logic [7:0]         char_sel;
    logic               unused_bits;

    assign bcd           = dd_q[35:16];
    assign s_axis_tready = tready_q;
    assign uart_tx       = tx_q;
    assign busy          = busy_q;
    assign unused_bits   = ^{s_axis_tdata[31:16], dd_adj[35]};

    // Add-3 correction on every BCD nibble that is 5 or more, ahead of the shift.
    always_comb begin
        dd_adj = dd_q;
        for (int i = 0; i < 5; i++) begin
            if (dd_q[16+4*i +: 4] >= 4'd5) begin
                dd_adj[16+4*i +: 4] = dd_q[16+4*i +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        char_sel = 8'h0A;
        case (char_idx_q)
            3'd0:    char_sel = {4'h3, bcd[19:16]};
            3'd1:    char_sel = {4'h3, bcd[15:12]};
            3'd2:    char_sel = {4'h3, bcd[11:8]};
            3'd3:    char_sel = {4'h3, bcd[7:4]};
            3'd4:    char_sel = {4'h3, bcd[3:0]};
            3'd5:    char_sel = 8'h0D;
            default: char_sel = 8'h0A;
        endcase
`ifdef LEADING_ZERO_BLANK_EN
        // A digit is blanked when it and every more significant digit are zero.
        case (char_idx_q)
            3'd0:    if (bcd[19:16] == 4'd0)  char_sel = 8'h20;
            3'd1:    if (bcd[19:12] == 8'd0)  char_sel = 8'h20;
            3'd2:    if (bcd[19:8] == 12'd0)  char_sel = 8'h20;
            3'd3:    if (bcd[19:4] == 16'd0)  char_sel = 8'h20;
            default: ;
        endcase
`endif
    end

    always_comb begin
        state_d    = state_q;
        data_d     = data_q;
        dd_d       = dd_q;
        conv_cnt_d = conv_cnt_q;
        char_idx_d = char_idx_q;
        baud_cnt_d = baud_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        tx_d       = tx_q;
        case (state_q)
            StIdle: begin
                if (s_axis_tvalid && tready_q) begin
                    data_d     = s_axis_tdata[15:0];
                    conv_cnt_d = 5'd0;
                    char_idx_d = 3'd0;
                    state_d    = StConvert;
                end
            end
            StConvert: begin
                // Step 0 seeds the shift register from the latched reading; steps 1..16 iterate.
                if (conv_cnt_q == 5'd0) begin
                    dd_d = {20'd0, data_q};
                end else begin
                    dd_d = {dd_adj[34:0], 1'b0};
                end
                conv_cnt_d = conv_cnt_q + 5'd1;
                if (conv_cnt_q == 5'd16) begin
                    state_d = StLoad;
                end
            end
            StLoad: begin
                tx_d       = 1'b0;
                shift_d    = {1'b1, char_sel};
                baud_cnt_d = '0;
                bit_cnt_d  = 4'd0;
                state_d    = StSend;
            end
            StSend: begin
                if (baud_cnt_q == BaudW'(BAUD_DIV - 1)) begin
                    baud_cnt_d = '0;
                    if (bit_cnt_q == 4'd9) begin
                        if (char_idx_q == 3'd6) begin
                            state_d = StIdle;
                        end else begin
                            char_idx_d = char_idx_q + 3'd1;
                            state_d    = StLoad;
                        end
                    end else begin
                        tx_d      = shift_q[0];
                        shift_d   = {1'b1, shift_q[8:1]};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            data_q     <= '0;
            dd_q       <= '0;
            conv_cnt_q <= '0;
            char_idx_q <= '0;
            baud_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            tx_q       <= 1'b1;
            tready_q   <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            data_q     <= data_d;
            dd_q       <= dd_d;
            conv_cnt_q <= conv_cnt_d;
            char_idx_q <= char_idx_d;
            baud_cnt_q <= baud_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            tready_q   <= (state_d == StIdle);
            busy_q     <= (state_d != StIdle);
        end
    end

endmodule

// File: tb/tb_voltage_uart_reporter.sv
// Directed bench for voltage_uart_reporter at BAUD_DIV = 8; a line monitor decodes frames into rx_q.
module tb_voltage_uart_reporter;
    logic        clk;
    logic        reset;
    logic [31:0] s_axis_tdata;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic        uart_tx;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int hs_cyc = 0;
    int rx_q[$];

    voltage_uart_reporter #(
        .CLK_HZ(100_000_000),
        .BAUD  (12_500_000)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .s_axis_tdata (s_axis_tdata),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready),
        .uart_tx      (uart_tx),
        .busy         (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Samples mid-bit on falling edges: start at +4.5 cycles, data bits every 8, stop at +76.5.
    initial begin : uart_monitor
        logic [7:0] b;
        logic       ok;
        forever begin
            @(negedge clk);
            if (reset === 1'b0 && uart_tx === 1'b0) begin
                ok = 1'b1;
                b  = 8'h00;
                for (int n = 1; n <= 76; n++) begin
                    @(negedge clk);
                    if (reset !== 1'b0) begin
                        ok = 1'b0;
                        break;
                    end
                    if (n == 4 && uart_tx !== 1'b0) ok = 1'b0;
                    if (n >= 12 && n <= 68 && (n % 8) == 4) b[3'((n - 12) / 8)] = uart_tx;
                    if (n == 76 && uart_tx !== 1'b1) ok = 1'b0;
                end
                if (ok) rx_q.push_back(int'(b));
                else if (reset === 1'b0) rx_q.push_back(-1);
            end
        end
    end

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Entered just after a rising edge; returns just after the handshake edge.
    task automatic send_word(input logic [31:0] d);
        int   n;
        logic hs;
        n  = 0;
        hs = 1'b0;
        s_axis_tdata  = d;
        s_axis_tvalid = 1'b1;
        while (!hs && n < 2000) begin
            @(negedge clk);
            hs = (s_axis_tready === 1'b1);
            @(posedge clk);
            #1;
            n++;
        end
        s_axis_tvalid = 1'b0;
        hs_cyc = cyc;
        chk("handshake", int'(hs), 1);
    endtask

    task automatic check_msg(input string tag, input logic [55:0] exp);
        int n;
        int got;
        n = 0;
        while (rx_q.size() < 7 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_count"}, (rx_q.size() >= 7) ? 7 : rx_q.size(), 7);
        for (int i = 0; i < 7; i++) begin
            got = (rx_q.size() > 0) ? rx_q.pop_front() : -2;
            chk(tag, got, int'(exp[55-8*i -: 8]));
        end
    endtask

    initial begin : stimulus
        int n;
        int t0;
        int low;
        int bad;

        reset         = 1'b1;
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = 32'h0;

        // Reset held, no input activity.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_tx", int'(uart_tx), 1);
        chk("rst_tready", int'(s_axis_tready), 1);
        chk("rst_busy", int'(busy), 0);
        bad = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (uart_tx !== 1'b1 || s_axis_tready !== 1'b1 || busy !== 1'b0) bad++;
        end
        chk("rst_stable", bad, 0);
        @(posedge clk);
        #1 reset = 1'b0;

        // 999 mV.
        send_word(32'h0000_03E7);
        @(negedge clk);
        chk("t1_busy", int'(busy), 1);
        chk("t1_tready", int'(s_axis_tready), 0);
`ifdef LEADING_ZERO_BLANK_EN
        check_msg("t1_byte", 56'h20_20_39_39_39_0D_0A);
`else
        check_msg("t1_byte", 56'h30_30_39_39_39_0D_0A);
`endif

        // Full-scale, upper half ignored.
        @(posedge clk);
        #1;
        send_word(32'hABCD_FFFF);
        check_msg("t2_byte", 56'h36_35_35_33_35_0D_0A);

        // Zero.
        @(posedge clk);
        #1;
        send_word(32'h0000_0000);
`ifdef LEADING_ZERO_BLANK_EN
        check_msg("t3_byte", 56'h20_20_20_20_30_0D_0A);
`else
        check_msg("t3_byte", 56'h30_30_30_30_30_0D_0A);
`endif

        // Timing and back-to-back acceptance; 10000 keeps the first data bit high.
        @(posedge clk);
        #1;
        send_word(32'h0000_2710);
        t0 = hs_cyc;
        s_axis_tdata  = 32'h0000_0001;
        s_axis_tvalid = 1'b1;
        n = 0;
        while (uart_tx !== 1'b0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("t4_fall", cyc - t0, 18);
        low = 0;
        while (uart_tx === 1'b0 && low < 20) begin
            @(negedge clk);
            low++;
        end
        chk("t4_start_len", low, 8);
        n = 0;
        while (s_axis_tready !== 1'b1 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("t4_tready_rise", cyc - t0, 584);
        @(posedge clk);
        #1 s_axis_tvalid = 1'b0;
        @(negedge clk);
        chk("t4_accept_tready", int'(s_axis_tready), 0);
        chk("t4_accept_busy", int'(busy), 1);
        check_msg("t4a_byte", 56'h31_30_30_30_30_0D_0A);
`ifdef LEADING_ZERO_BLANK_EN
        check_msg("t4b_byte", 56'h20_20_20_20_31_0D_0A);
`else
        check_msg("t4b_byte", 56'h30_30_30_30_31_0D_0A);
`endif

        // Reset during the data bits of the third character (line time T+188..T+252).
        @(posedge clk);
        #1;
        send_word(32'h0000_3039);
        repeat (199) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("t5_tx", int'(uart_tx), 1);
        chk("t5_busy", int'(busy), 0);
        chk("t5_tready", int'(s_axis_tready), 1);
        chk("t5_partial_count", rx_q.size(), 2);
        chk("t5_partial0", (rx_q.size() > 0) ? rx_q.pop_front() : -2, 8'h31);
        chk("t5_partial1", (rx_q.size() > 0) ? rx_q.pop_front() : -2, 8'h32);
        rx_q.delete();
        @(posedge clk);
        #1;
        send_word(32'h0000_D431);
        check_msg("t5_byte", 56'h35_34_33_32_31_0D_0A);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
